round_robin_arbiter: RTL and testbench

ROUND_ROBIN_ARBITER -- requirements
Module: round_robin_arbiter

---
 rtl/arb_pkg.sv | 14 +
 rtl/rr_pick.sv | 34 +++
 rtl/round_robin_arbiter.sv | 96 +++++++++
 tb/tb_round_robin_arbiter.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared sizes and state type for the round-robin arbiter.
package arb_pkg;

  localparam int NREQ        = 4;
  localparam int NBITS_QUANT = 4;
  localparam int OWNER_W     = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating priority search: first set req bit at or above the one-hot ptr, wrapping.
module rr_pick import arb_pkg::*; #(
  parameter int NREQ = arb_pkg::NREQ,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] ptr,
  output logic [NREQ-1:0] pick,
  output logic [IW-1:0]   pick_idx
);

  always_comb begin
    int   base;
    int   idx;
    logic found;
    base     = 0;
    idx      = 0;
    found    = 1'b0;
    pick     = '0;
    pick_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (ptr[i]) base = i;
    end
    for (int k = 0; k < NREQ; k++) begin
      idx = (base + k) % NREQ;
      if (!found && req[idx]) begin
        found     = 1'b1;
        pick[idx] = 1'b1;
        pick_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter with per-grant quantum preemption and a one-cycle gap between grants.
module round_robin_arbiter import arb_pkg::*; #(
  parameter int NREQ        = arb_pkg::NREQ,
  parameter int NBITS_QUANT = arb_pkg::NBITS_QUANT
) (
  input  logic                     clk_2,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [NREQ-1:0]          req,
  input  logic [NBITS_QUANT-1:0]   quantum,
  output logic [NREQ-1:0]          gnt,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic [NREQ-1:0]          ptr,
  output logic                     preempt
);

  localparam int IW = $clog2(NREQ);

  arb_state_t             state;
  arb_state_t             state_next;
  logic [NBITS_QUANT-1:0] count;
  logic [NREQ-1:0]        pick;
  logic [IW-1:0]          pick_idx;
  logic                   owner_req;
  logic                   others_req;
  logic                   quantum_hit;
  logic                   start_grant;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req      (req),
    .ptr      (ptr),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

  assign owner_req   = |(req & gnt);
  assign others_req  = |(req & ~gnt);
  assign quantum_hit = (quantum != '0) && (count >= quantum) && others_req;
  assign start_grant = enable && (req != '0);

  always_ff @(posedge clk_2) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // GAP arbitrates like IDLE so the idle gap between grants is exactly one cycle.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_GAP: state_next = start_grant ? ST_GRANT : ST_IDLE;
      ST_GRANT:        if (!owner_req || quantum_hit) state_next = ST_GAP;
      default:         state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    preempt = 1'b0;
    if (state == ST_GRANT && owner_req && quantum_hit) preempt = 1'b1;
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      gnt   <= '0;
      owner <= '0;
      ptr   <= NREQ'(1);
      count <= '0;
    end else begin
      case (state_next)
        ST_GRANT: begin
          if (state != ST_GRANT) begin
            gnt   <= pick;
            owner <= pick_idx;
            count <= NBITS_QUANT'(1);
          end else if (count != '1) begin
            count <= count + 1'b1;
          end
        end
        ST_GAP: begin
          gnt   <= '0;
          owner <= '0;
          count <= '0;
          ptr   <= {gnt[NREQ-2:0], gnt[NREQ-1]};
        end
        default: begin
          gnt   <= '0;
          owner <= '0;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Directed table-driven bench for round_robin_arbiter plus long-grant sequences.
module tb_round_robin_arbiter;

  logic       clk_2;
  logic       reset;
  logic       enable;
  logic [3:0] req;
  logic [3:0] quantum;
  logic [3:0] gnt;
  logic [1:0] owner;
  logic [3:0] ptr;
  logic       preempt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] req;
    logic [3:0] q;
    logic [3:0] gnt;
    logic [1:0] own;
    logic [3:0] ptr;
    logic       pre;
  } vec_t;

  vec_t vecs[$];

  round_robin_arbiter #(
    .NREQ        (4),
    .NBITS_QUANT (4)
  ) dut (
    .clk_2   (clk_2),
    .reset   (reset),
    .enable  (enable),
    .req     (req),
    .quantum (quantum),
    .gnt     (gnt),
    .owner   (owner),
    .ptr     (ptr),
    .preempt (preempt)
  );

  initial clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  task automatic applyStimulus(input logic rst, input logic en, input logic [3:0] r, input logic [3:0] q);
    reset   = rst;
    enable  = en;
    req     = r;
    quantum = q;
  endtask

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] e_gnt, input logic [1:0] e_own,
                             input logic [3:0] e_ptr, input logic e_pre);
    checkValue({tag, " gnt"}, 32'(gnt), 32'(e_gnt));
    checkValue({tag, " owner"}, 32'(owner), 32'(e_own));
    checkValue({tag, " ptr"}, 32'(ptr), 32'(e_ptr));
    checkValue({tag, " preempt"}, 32'(preempt), 32'(e_pre));
    checkValue({tag, " onehot"}, 32'($countones(gnt) <= 1), 32'd1);
  endtask

  task automatic step();
    @(posedge clk_2);
    #1;
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0, 4'b0000, 4'd0);

    //                rst   en    req      q      gnt      own   ptr      pre
    vecs.push_back(vec_t'{1'b1, 1'b0, 4'b0000, 4'd0, 4'b0000, 2'd0, 4'b0001, 1'b0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 4'b1010, 4'd0, 4'b0010, 2'd1, 4'b0001, 1'b0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 4'b1000, 4'd0, 4'b0000, 2'd0, 4'b0100, 1'b0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 4'b1000, 4'd0, 4'b1000, 2'd3, 4'b0100, 1'b0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 4'b0000, 4'd0, 4'b0000, 2'd0, 4'b0001, 1'b0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 4'b0000, 4'd0, 4'b0000, 2'd0, 4'b0001, 1'b0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 4'b0100, 4'd0, 4'b0100, 2'd2, 4'b0001, 1'b0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 4'b0000, 4'd0, 4'b0000, 2'd0, 4'b1000, 1'b0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 4'b0001, 4'd0, 4'b0001, 2'd0, 4'b1000, 1'b0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 4'b0000, 4'd0, 4'b0000, 2'd0, 4'b0010, 1'b0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 4'b0000, 4'd0, 4'b0000, 2'd0, 4'b0010, 1'b0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 4'b1001, 4'd0, 4'b1000, 2'd3, 4'b0010, 1'b0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 4'b0001, 4'd0, 4'b0000, 2'd0, 4'b0001, 1'b0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 4'b0001, 4'd0, 4'b0001, 2'd0, 4'b0001, 1'b0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 4'b0000, 4'd0, 4'b0000, 2'd0, 4'b0010, 1'b0});
    vecs.push_back(vec_t'{1'b1, 1'b1, 4'b0011, 4'd3, 4'b0000, 2'd0, 4'b0001, 1'b0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 4'b0011, 4'd3, 4'b0001, 2'd0, 4'b0001, 1'b0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 4'b0011, 4'd3, 4'b0001, 2'd0, 4'b0001, 1'b0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 4'b0011, 4'd3, 4'b0001, 2'd0, 4'b0001, 1'b1});
    vecs.push_back(vec_t'{1'b0, 1'b1, 4'b0011, 4'd3, 4'b0000, 2'd0, 4'b0010, 1'b0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 4'b0011, 4'd3, 4'b0010, 2'd1, 4'b0010, 1'b0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 4'b0011, 4'd1, 4'b0000, 2'd0, 4'b0100, 1'b0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 4'b0000, 4'd0, 4'b0000, 2'd0, 4'b0100, 1'b0});
    vecs.push_back(vec_t'{1'b0, 1'b0, 4'b1111, 4'd0, 4'b0000, 2'd0, 4'b0100, 1'b0});
    vecs.push_back(vec_t'{1'b0, 1'b0, 4'b1111, 4'd0, 4'b0000, 2'd0, 4'b0100, 1'b0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 4'b1111, 4'd0, 4'b0100, 2'd2, 4'b0100, 1'b0});
    vecs.push_back(vec_t'{1'b0, 1'b0, 4'b1111, 4'd0, 4'b0100, 2'd2, 4'b0100, 1'b0});
    vecs.push_back(vec_t'{1'b0, 1'b0, 4'b1011, 4'd0, 4'b0000, 2'd0, 4'b1000, 1'b0});
    vecs.push_back(vec_t'{1'b0, 1'b0, 4'b1011, 4'd0, 4'b0000, 2'd0, 4'b1000, 1'b0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 4'b1011, 4'd0, 4'b1000, 2'd3, 4'b1000, 1'b0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 4'b1011, 4'd0, 4'b1000, 2'd3, 4'b1000, 1'b0});
    vecs.push_back(vec_t'{1'b1, 1'b1, 4'b1011, 4'd0, 4'b0000, 2'd0, 4'b0001, 1'b0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 4'b1011, 4'd0, 4'b0001, 2'd0, 4'b0001, 1'b0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 4'b0000, 4'd0, 4'b0000, 2'd0, 4'b0010, 1'b0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 4'b0000, 4'd0, 4'b0000, 2'd0, 4'b0010, 1'b0});

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].req, vecs[i].q);
      step();
      checkOutput($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].own, vecs[i].ptr, vecs[i].pre);
    end

    // Lone requester with an expired quantum keeps its grant and is never preempted.
    applyStimulus(1'b0, 1'b1, 4'b0100, 4'd2);
    for (int c = 0; c < 10; c++) begin
      step();
      checkOutput($sformatf("hold%0d", c), 4'b0100, 2'd2, 4'b0010, 1'b0);
    end

    // Ten more cycles push the grant counter past its all-ones saturation point.
    applyStimulus(1'b0, 1'b1, 4'b0100, 4'd0);
    for (int c = 0; c < 10; c++) begin
      step();
      checkOutput($sformatf("sat%0d", c), 4'b0100, 2'd2, 4'b0010, 1'b0);
    end
    applyStimulus(1'b0, 1'b1, 4'b0101, 4'd15);
    #1;
    checkValue("sat preempt", 32'(preempt), 32'd1);
    step();
    checkOutput("sat gap", 4'b0000, 2'd0, 4'b1000, 1'b0);
    step();
    checkOutput("sat regrant", 4'b0001, 2'd0, 4'b1000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
